// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: TX FIFO + serializer, single-byte RX holding register, programmable divisor.
// Define UART_RX_EN to build the receiver; without it RX status reads zero and rx is ignored.
module bus_uart #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [15:0] DEFAULT_DIV = 16'd434,
    parameter int          TX_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] busAddress,
    input  logic [31:0] busDataIn,
    input  logic        busWriteEnable,
    output logic [31:0] busDataOut,
    output logic        tx,
    input  logic        rx
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} uart_state_e;

    logic        sel_s, wr_s, clr_s, push_req_s, push_s, pop_s, full_s, nempty_s, tx_busy_s;
    logic [1:0]  off_s;
    logic [15:0] div_q, div_eff_s;
    logic        tx_overflow_q;
    logic        rx_valid_s, rx_overrun_s;
    logic [7:0]  rx_byte_s;
    logic        unused_s;

    assign sel_s      = (busAddress[31:4] == BASE_ADDR[31:4]);
    assign off_s      = busAddress[3:2];
    assign wr_s       = sel_s && busWriteEnable;
    assign clr_s      = wr_s && (off_s == 2'd2);
    assign push_req_s = wr_s && (off_s == 2'd0);
    assign div_eff_s  = (div_q == 16'd0) ? 16'd1 : div_q;
    assign unused_s   = ^{busDataIn[31:16], busAddress[1:0], rx};

    // Divisor and TX overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= DEFAULT_DIV;
            tx_overflow_q <= 1'b0;
        end else begin
            if (wr_s && (off_s == 2'd3)) div_q <= busDataIn[15:0];
            if (push_req_s && full_s) tx_overflow_q <= 1'b1;
            else if (clr_s && busDataIn[4]) tx_overflow_q <= 1'b0;
        end
    end

    // TX FIFO: a push against a full FIFO is dropped even if a pop happens on the same edge
    logic [7:0]    fifo_mem_q [TX_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;

    assign full_s   = (count_q == DEPTH_C);
    assign nempty_s = (count_q != {(AW + 1){1'b0}});
    assign push_s   = push_req_s && !full_s;

    // FIFO storage (contents are meaningless once the pointers reset)
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_q[wptr_q] <= busDataIn[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) wptr_q <= wptr_q + {{(AW - 1){1'b0}}, 1'b1};
            if (pop_s)  rptr_q <= rptr_q + {{(AW - 1){1'b0}}, 1'b1};
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + {{AW{1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{AW{1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

    // TX serializer
    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_bdiv_q, tx_bdiv_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d, tx_bit_end_s;

    assign tx_bit_end_s = (tx_cnt_q == (tx_bdiv_q - 16'd1));
    assign tx_busy_s    = (tx_state_q != S_IDLE) || nempty_s;
    assign tx           = tx_q;

    // TX state register
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bdiv_q  <= 16'd1;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bdiv_q  <= tx_bdiv_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    // TX next-state: pops happen only when leaving IDLE or STOP into START
    always_comb begin
        tx_state_d = tx_state_q;
        pop_s      = 1'b0;
        case (tx_state_q)
            S_IDLE:  if (nempty_s) begin tx_state_d = S_START; pop_s = 1'b1; end
            S_START: if (tx_bit_end_s) tx_state_d = S_DATA;
            S_DATA:  if (tx_bit_end_s && (tx_bit_q == 3'd7)) tx_state_d = S_STOP;
            S_STOP: begin
                if (tx_bit_end_s) begin
                    if (nempty_s) begin tx_state_d = S_START; pop_s = 1'b1; end
                    else tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // TX outputs: bit timer re-latches the divisor at each bit boundary
    always_comb begin
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bdiv_d  = tx_bdiv_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (pop_s) begin
            tx_shift_d = fifo_mem_q[rptr_q];
            tx_cnt_d   = 16'd0;
            tx_bdiv_d  = div_eff_s;
            tx_bit_d   = 3'd0;
        end else if (tx_state_q == S_IDLE) begin
            tx_cnt_d = 16'd0;
        end else if (tx_bit_end_s) begin
            tx_cnt_d  = 16'd0;
            tx_bdiv_d = div_eff_s;
            if (tx_state_q == S_DATA) begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end
        case (tx_state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

`ifdef UART_RX_EN
    uart_state_e rx_state_q, rx_state_d;
    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_bdiv_q, rx_bdiv_d, rx_target_s;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q;
    logic        rx_valid_q, rx_overrun_q, rx_sample_s, rx_load_s, rx_ovr_s;

    assign rx_target_s  = (rx_state_q == S_START) ? (rx_bdiv_q >> 1) : (rx_bdiv_q - 16'd1);
    assign rx_sample_s  = (rx_state_q != S_IDLE) && (rx_cnt_q >= rx_target_s);
    assign rx_valid_s   = rx_valid_q;
    assign rx_overrun_s = rx_overrun_q;
    assign rx_byte_s    = rx_byte_q;

    // RX state register, synchronizer and holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1_q   <= 1'b1;
            rx_sync2_q   <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= 16'd0;
            rx_bdiv_q    <= 16'd1;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            rx_byte_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_sync1_q <= rx;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bdiv_q  <= rx_bdiv_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            if (rx_load_s) rx_byte_q <= rx_shift_q;
            if (rx_load_s) rx_valid_q <= 1'b1;
            else if (clr_s && busDataIn[0]) rx_valid_q <= 1'b0;
            if (rx_ovr_s) rx_overrun_q <= 1'b1;
            else if (clr_s && busDataIn[3]) rx_overrun_q <= 1'b0;
        end
    end

    // RX next-state: a high line at mid-start is a false start
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            S_IDLE:  if (rx_prev_q && !rx_sync2_q) rx_state_d = S_START;
            S_START: if (rx_sample_s) rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
            S_DATA:  if (rx_sample_s && (rx_bit_q == 3'd7)) rx_state_d = S_STOP;
            S_STOP:  if (rx_sample_s) rx_state_d = S_IDLE;
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX outputs: start count preloaded with the synchronizer/detect latency
    always_comb begin
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bdiv_d  = rx_bdiv_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_load_s  = 1'b0;
        rx_ovr_s   = 1'b0;
        if (rx_state_q == S_IDLE) begin
            rx_cnt_d  = 16'd2;
            rx_bdiv_d = div_eff_s;
            rx_bit_d  = 3'd0;
        end else if (rx_sample_s) begin
            rx_cnt_d  = 16'd0;
            rx_bdiv_d = div_eff_s;
            if (rx_state_q == S_DATA) begin
                rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
            end else if ((rx_state_q == S_STOP) && rx_sync2_q) begin
                if (!rx_valid_q || (clr_s && busDataIn[0])) rx_load_s = 1'b1;
                else rx_ovr_s = 1'b1;
            end else begin
                rx_bit_d = 3'd0;
            end
        end else begin
            rx_cnt_d = rx_cnt_q + 16'd1;
        end
    end
`else
    assign rx_valid_s   = 1'b0;
    assign rx_overrun_s = 1'b0;
    assign rx_byte_s    = 8'h00;
`endif

    // Combinational read mux, zero outside the window so it can be OR-merged
    always_comb begin
        busDataOut = 32'h0000_0000;
        if (sel_s) begin
            case (off_s)
                2'd1:    busDataOut = {23'h0, rx_valid_s, rx_byte_s};
                2'd2:    busDataOut = {27'h0, tx_overflow_q, rx_overrun_s, tx_busy_s, full_s, rx_valid_s};
                2'd3:    busDataOut = {16'h0, div_q};
                default: busDataOut = 32'h0000_0000;
            endcase
        end else begin
            busDataOut = 32'h0000_0000;
        end
    end
endmodule

// File: doc/bus_uart.md
# bus_uart

Memory-mapped UART peripheral on the CPU data bus, downstream of the CPU core: decodes the CPU's address, write data and write enable, and returns read data for the CPU's data input. Contains a TX FIFO feeding an 8N1 serializer, a single-byte RX holding register, and a programmable bit divisor. Read data is combinational and zero when the peripheral is not addressed, so it can be OR-merged with other peripherals.

## Interface
- BASE_ADDR, 32'h8000_0000, base of 16-byte register window; bits [3:0] must be 0
- DEFAULT_DIV, 16'd434, divisor reset value in clocks per bit
- TX_DEPTH, 8, TX FIFO entries; power of two, 2 to 64
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- busAddress  input  32  CPU byte address
- busDataIn  input  32  CPU write data
- busWriteEnable  input  1  1 = write, 0 = read
- busDataOut  output  32  read data; 0 when address outside window
- tx  output  1  serial out, idle high, registered
- rx  input  1  serial in, asynchronous

## Operation
- Selected when busAddress[31:4] == BASE_ADDR[31:4]; busAddress[1:0] ignored; offset = busAddress[3:2].
- Offset 0x0 TXDATA: write pushes busDataIn[7:0]; read returns 0.
- Offset 0x4 RXDATA: read {23'b0, rxValid, rxByte}; no read side effects; writes ignored.
- Offset 0x8 STATUS: read {27'b0, txOverflow, rxOverrun, txBusy, txFull, rxValid}; write 1 to bit0/bit3/bit4 clears rxValid/rxOverrun/txOverflow; other bits ignored.
- Offset 0xC DIVISOR: read/write bits[15:0]; value 0 behaves as 1.
- Each clock with selected write performs one write; holding busWriteEnable N cycles performs N writes.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE or START if FIFO non-empty. Pop occurs on IDLE/STOP exit into START.
- txBusy = FSM not IDLE or FIFO non-empty.
- Push while full (pre-edge count == TX_DEPTH): byte dropped, txOverflow set, even if pop happens same edge.
- RX: 2-flop synchronizer; FSM IDLE -> START on falling edge -> sample mid-bit (DIVISOR/2 after edge); high at mid-start returns IDLE (false start). DATA samples every DIVISOR clocks; STOP sample high: if rxValid clear, load rxByte and set rxValid, else drop byte and set rxOverrun. STOP sample low (framing error): byte discarded, no flag.
- Simultaneous rxValid clear and new byte completion: new byte loaded, rxValid stays 1, no overrun.
- Reset values: tx=1, FIFO empty, both FSMs IDLE, rxByte=0, all flags 0, DIVISOR=DEFAULT_DIV; busDataOut follows decode immediately.

## Timing
- Register write visible to reads the cycle after the write edge.
- TXDATA write at edge N into idle UART: tx low from edge N+1; each bit lasts exactly DIVISOR clocks; frame = 10*DIVISOR clocks; back-to-back frames without idle gap.
- DIVISOR write takes effect at next bit boundary of each FSM.
- rxValid rises 2 clocks (synchronizer) plus 9.5*DIVISOR clocks after rx falling edge, ±1 clock.
- Reset mid-frame: tx high after that edge, FIFO flushed, partial RX byte discarded.

## Configuration
- UART_RX_EN defined: receiver as above.
- Undefined: receiver logic omitted; rx unused; RXDATA reads 0; STATUS bits 0 and 3 read 0; their clear writes ignored.

## Test plan
- Reset, DIVISOR=4, write 0x55 to TXDATA -> tx low 4 clocks then 1,0,1,0,1,0,1,0 at 4 clocks each, stop high; txBusy 0 after 40 clocks.
- Write 9 bytes back-to-back with TX_DEPTH=8 and DIVISOR=100 -> first popped at once so 8 queued, 9th accepted; 10th write sets txOverflow; STATUS bit4 clear returns 0.
- Drive rx frame 0xA3 at DIVISOR=8 -> RXDATA reads 0x1A3; second frame without clear -> RXDATA still 0x1A3, rxOverrun=1.
- rx low pulse of 2 clocks at DIVISOR=8 -> no rxValid; frame with low stop bit -> no rxValid, no flags.
- Reads/writes at BASE_ADDR+0x10 and BASE_ADDR-4 -> busDataOut 0, no state change.
- Assert reset mid TX frame -> tx=1 next cycle, STATUS reads 0, DIVISOR reads DEFAULT_DIV.
